// File: rtl/dbg_step_ctrl_if.sv
// Host register slave bus for dbg_step_ctrl: single-cycle writes,
// reads answered one cycle later with a valid pulse.
interface dbg_step_ctrl_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [W-1:0]      avs_writedata;
    logic [W-1:0]      avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/dbg_step_ctrl.sv
// Debug run control: gates the core clock enable (run/halt/step/breakpoint)
// and snapshots the debug channels whenever the core halts.
module dbg_step_ctrl #(
    parameter int W            = 32,
    parameter int CHANNELS     = 33,
    parameter int ADDR_W       = 6,
    parameter int RUN_ON_RESET = 0
) (
    input  logic                  dbg_clk_clk,
    input  logic                  dbg_reset_reset,
    input  logic [CHANNELS*W-1:0] dbg_chan_export,
    output logic                  dbg_clock_export,
    dbg_step_ctrl_if.slave        avs
);
    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } state_e;

    localparam state_e RESET_STATE = (RUN_ON_RESET != 0) ? RUNNING : HALTED;
    localparam logic   RESET_RUN   = (RUN_ON_RESET != 0);

    state_e                state_q, state_d;
    logic [W-1:0]          remain_q, remain_d;
    logic [W-1:0]          step_cnt_q, step_cnt_d;
    logic [W-1:0]          bkpt_q, bkpt_d;
    logic [W-1:0]          cycle_q, cycle_d;
    logic [W-1:0]          rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic                  hit_q, hit_d;
    logic                  snap_valid_q, snap_valid_d;
    logic                  run_first_q, run_first_d;
    logic                  halt_first_q, halt_first_d;
    logic [CHANNELS*W-1:0] snap_q, snap_d;

    logic         ctrl_wr;
    logic         do_run, do_halt, do_step, do_snap, do_clr;
    logic         status_rd;
    logic         bkpt_match;
    logic         capture;
    logic [W-1:0] status;
    logic [W-1:0] rd_mux;

    assign ctrl_wr   = avs.avs_write && (avs.avs_address == '0);
    assign do_run    = ctrl_wr && avs.avs_writedata[0];
    assign do_halt   = ctrl_wr && avs.avs_writedata[1];
    assign do_step   = ctrl_wr && avs.avs_writedata[2];
    assign do_snap   = ctrl_wr && avs.avs_writedata[3];
    assign do_clr    = ctrl_wr && avs.avs_writedata[4];
    assign status_rd = avs.avs_read && (avs.avs_address == ADDR_W'(1));

    // The first running cycle ignores the compare so the core can leave a breakpoint.
    assign bkpt_match = (state_q == RUNNING) && !run_first_q && bkpt_q[0]
                     && (dbg_chan_export[W-1:2] == bkpt_q[W-1:2]);

    assign dbg_clock_export = ((state_q == RUNNING) && !bkpt_match)
                           || (state_q == STEPPING);

    assign capture = do_snap || halt_first_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        err_d    = err_q && !status_rd;
        hit_d    = hit_q && !status_rd;
        unique case (state_q)
            HALTED: begin
                if (!do_halt) begin
                    if (do_step) begin
                        if (step_cnt_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            state_d  = STEPPING;
                            remain_d = step_cnt_q;
                        end
                    end else if (do_run) begin
                        state_d = RUNNING;
                    end
                end
            end
            RUNNING: begin
                if (do_halt) begin
                    state_d = HALTED;
                end else begin
                    if (do_step) err_d = 1'b1;
                    if (bkpt_match) begin
                        state_d = HALTED;
                        hit_d   = 1'b1;
                    end
                end
            end
            STEPPING: begin
                remain_d = remain_q - W'(1);
                if (do_halt || (remain_q == W'(1))) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        step_cnt_d = step_cnt_q;
        bkpt_d     = bkpt_q;
        if (avs.avs_write && (avs.avs_address == ADDR_W'(2)))
            step_cnt_d = avs.avs_writedata;
        if (avs.avs_write && (avs.avs_address == ADDR_W'(3)))
            bkpt_d = {avs.avs_writedata[W-1:2], 1'b0, avs.avs_writedata[0]};
        cycle_d = do_clr ? '0 : cycle_q + {{(W-1){1'b0}}, dbg_clock_export};
        snap_d  = capture ? dbg_chan_export : snap_q;
        snap_valid_d = snap_valid_q;
        if ((state_q == HALTED) && (state_d != HALTED)) snap_valid_d = 1'b0;
        if (capture) snap_valid_d = 1'b1;
        halt_first_d = (state_q != HALTED) && (state_d == HALTED);
        run_first_d  = (state_q != RUNNING) && (state_d == RUNNING);
    end

    always_comb begin
        status      = '0;
        status[4:0] = {hit_q, err_q, snap_valid_q, state_q};
        rd_mux      = '0;
        case (avs.avs_address)
            ADDR_W'(1): rd_mux = status;
            ADDR_W'(2): rd_mux = step_cnt_q;
            ADDR_W'(3): rd_mux = bkpt_q;
            ADDR_W'(4): rd_mux = cycle_q;
            default: begin
                for (int i = 0; i < CHANNELS; i++)
                    if (avs.avs_address == ADDR_W'(i + 5))
                        rd_mux = snap_q[i*W +: W];
            end
        endcase
        rdata_d  = avs.avs_read ? rd_mux : rdata_q;
        rvalid_d = avs.avs_read;
    end

    always_ff @(posedge dbg_clk_clk or posedge dbg_reset_reset) begin
        if (dbg_reset_reset) begin
            state_q      <= RESET_STATE;
            remain_q     <= '0;
            step_cnt_q   <= '0;
            bkpt_q       <= '0;
            cycle_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            hit_q        <= 1'b0;
            snap_valid_q <= 1'b0;
            run_first_q  <= RESET_RUN;
            halt_first_q <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            step_cnt_q   <= step_cnt_d;
            bkpt_q       <= bkpt_d;
            cycle_q      <= cycle_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            hit_q        <= hit_d;
            snap_valid_q <= snap_valid_d;
            run_first_q  <= run_first_d;
            halt_first_q <= halt_first_d;
            snap_q       <= snap_d;
        end
    end

    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Bench for dbg_step_ctrl: emulated core PC, cycle-level reference model,
// per-cycle compare plus directed literal checks; small instance for CYCLE wrap.
module tb_dbg_step_ctrl;
    localparam int W  = 32;
    localparam int CH = 33;
    localparam int AW = 6;
    localparam logic [31:0] K = 32'h0010_0001;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic [31:0] pc = 32'd0;
    logic [CH*W-1:0] chan;
    logic [15:0] chan2 = 16'hA55A;
    logic clk_en, clk_en2;
    int vectors = 0;
    int miscompares = 0;

    dbg_step_ctrl_if #(.W(W), .ADDR_W(AW)) bus ();
    dbg_step_ctrl_if #(.W(8), .ADDR_W(3)) bus2 ();

    dbg_step_ctrl #(.W(W), .CHANNELS(CH), .ADDR_W(AW), .RUN_ON_RESET(0)) dut (
        .dbg_clk_clk(clk),
        .dbg_reset_reset(rst),
        .dbg_chan_export(chan),
        .dbg_clock_export(clk_en),
        .avs(bus)
    );

    dbg_step_ctrl #(.W(8), .CHANNELS(2), .ADDR_W(3), .RUN_ON_RESET(1)) dut2 (
        .dbg_clk_clk(clk),
        .dbg_reset_reset(rst2),
        .dbg_chan_export(chan2),
        .dbg_clock_export(clk_en2),
        .avs(bus2)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < CH; i++) chan[i*W +: W] = pc + K * 32'(i);
    end

    // reference model state
    int mode, cyc_no, step_end, run_start, halt_start;
    logic [31:0] m_cyc, m_stepcnt, m_bkpt;
    bit m_err, m_hit, m_sv;
    logic [31:0] m_snap [CH];
    bit exp_rv;
    logic [31:0] exp_rd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit m_match();
        return mode == M_RUN && cyc_no > run_start + 1 && m_bkpt[0]
            && pc[31:2] == m_bkpt[31:2];
    endfunction

    function automatic bit m_en();
        return mode == M_STEP || (mode == M_RUN && !m_match());
    endfunction

    function automatic logic [31:0] m_read(logic [5:0] a);
        int ia;
        ia = int'(a);
        if (ia == 1) return {27'd0, m_hit, m_err, m_sv, 2'(mode)};
        if (ia == 2) return m_stepcnt;
        if (ia == 3) return m_bkpt;
        if (ia == 4) return m_cyc;
        if (ia >= 5 && ia < 5 + CH) return m_snap[ia - 5];
        return 32'd0;
    endfunction

    task automatic model_reset();
        mode = M_HALT; cyc_no = 0; step_end = 0;
        run_start = -10; halt_start = -10;
        m_cyc = 0; m_stepcnt = 0; m_bkpt = 0;
        m_err = 0; m_hit = 0; m_sv = 0;
        for (int i = 0; i < CH; i++) m_snap[i] = 32'd0;
        exp_rv = 0; exp_rd = 32'd0;
    endtask

    task automatic model_edge();
        logic [31:0] wc;
        bit en_now, match, capture;
        int prev;
        en_now = m_en();
        match  = m_match();
        exp_rv = bus.avs_read;
        if (bus.avs_read) exp_rd = m_read(bus.avs_address);
        wc = (bus.avs_write && bus.avs_address == 0) ? bus.avs_writedata : 32'd0;
        capture = wc[3] || (mode == M_HALT && cyc_no == halt_start + 1);
        if (capture)
            for (int i = 0; i < CH; i++) m_snap[i] = pc + K * 32'(i);
        if (bus.avs_read && bus.avs_address == 1) begin
            m_err = 0; m_hit = 0;
        end
        prev = mode;
        if (mode == M_HALT && !wc[1]) begin
            if (wc[2]) begin
                if (m_stepcnt == 0) m_err = 1;
                else begin
                    mode = M_STEP;
                    step_end = cyc_no + int'(m_stepcnt);
                end
            end else if (wc[0]) mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (wc[1]) mode = M_HALT;
            else begin
                if (wc[2]) m_err = 1;
                if (match) begin mode = M_HALT; m_hit = 1; end
            end
        end else if (mode == M_STEP) begin
            if (wc[1] || cyc_no == step_end) mode = M_HALT;
        end
        if (prev != M_HALT && mode == M_HALT) halt_start = cyc_no;
        if (prev != M_RUN && mode == M_RUN) run_start = cyc_no;
        if (prev == M_HALT && mode != M_HALT) m_sv = 0;
        if (capture) m_sv = 1;
        m_cyc = wc[4] ? 32'd0 : m_cyc + 32'(en_now);
        if (bus.avs_write && bus.avs_address == 2) m_stepcnt = bus.avs_writedata;
        if (bus.avs_write && bus.avs_address == 3)
            m_bkpt = bus.avs_writedata & 32'hFFFF_FFFD;
        cyc_no++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("clock_en", 32'(clk_en), 32'(m_en()));
            chk("rvalid", 32'(bus.avs_readdatavalid), 32'(exp_rv));
            if (exp_rv) chk("rdata", bus.avs_readdata, exp_rd);
        end
    end

    task automatic cyc();
        bit e;
        @(negedge clk);
        e = clk_en;
        @(posedge clk);
        #1;
        if (e) pc = pc + 32'd4;
        bus.avs_read = 0; bus.avs_write = 0;
        bus2.avs_read = 0; bus2.avs_write = 0;
    endtask

    task automatic wr(logic [5:0] a, logic [31:0] d);
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1;
        cyc();
    endtask

    task automatic rd_lit(string name, logic [5:0] a, logic [31:0] v);
        bus.avs_address = a; bus.avs_read = 1;
        cyc();
        chk({name, "_valid"}, 32'(bus.avs_readdatavalid), 32'd1);
        chk(name, bus.avs_readdata, v);
    endtask

    task automatic rd2_lit(string name, logic [2:0] a, logic [7:0] v);
        bus2.avs_address = a; bus2.avs_read = 1;
        cyc();
        chk({name, "_valid"}, 32'(bus2.avs_readdatavalid), 32'd1);
        chk(name, 32'(bus2.avs_readdata), 32'(v));
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_read = 0; bus.avs_write = 0;
        bus.avs_writedata = '0;
        bus2.avs_address = '0; bus2.avs_read = 0; bus2.avs_write = 0;
        bus2.avs_writedata = '0;
        repeat (3) cyc();
        rst = 0;
        chk("rst_en", 32'(clk_en), 32'd0);
        rd_lit("rst_status", 6'd1, 32'd0);
        for (int a = 5; a < 5 + CH; a++) rd_lit("rst_snap", 6'(a), 32'd0);
        rd_lit("rst_cycle", 6'd4, 32'd0);
        rd_lit("rst_ctrl", 6'd0, 32'd0);
        rd_lit("unmapped", 6'd63, 32'd0);

        // three-cycle step from PC 0
        wr(6'd2, 32'd3);
        wr(6'd0, 32'h4);
        repeat (5) cyc();
        rd_lit("step_cycle", 6'd4, 32'd3);
        rd_lit("step_status", 6'd1, 32'h4);
        rd_lit("step_snap_pc", 6'd5, 32'd12);
        rd_lit("step_snap_x0", 6'd6, 32'h0010_000D);
        rd_lit("step_snap_x31", 6'd37, 32'h0200_002C);
        rd_lit("stepcnt_rb", 6'd2, 32'd3);

        // breakpoint at 0x100
        pc = 32'hF0;
        wr(6'd3, 32'h101);
        wr(6'd0, 32'h1);
        repeat (6) cyc();
        chk("bkpt_pc_hold", pc, 32'h100);
        rd_lit("bkpt_status", 6'd1, 32'h14);
        rd_lit("bkpt_snap_pc", 6'd5, 32'h100);
        rd_lit("bkpt_status_clr", 6'd1, 32'h4);
        wr(6'd0, 32'h1);
        repeat (3) cyc();
        chk("run_off_bkpt", pc, 32'h10C);

        // ignored commands while running
        wr(6'd0, 32'h4);
        rd_lit("run_step_err", 6'd1, 32'h9);
        rd_lit("err_cleared", 6'd1, 32'h1);
        wr(6'd0, 32'h1);
        rd_lit("run_run_noerr", 6'd1, 32'h1);
        wr(6'd0, 32'h8);
        rd_lit("run_snap", 6'd1, 32'h5);
        wr(6'd0, 32'h7);
        chk("halt_prio_en", 32'(clk_en), 32'd0);
        rd_lit("halt_prio_status", 6'd1, 32'h4);

        // step with zero count
        wr(6'd2, 32'd0);
        wr(6'd0, 32'h4);
        rd_lit("zero_step_err", 6'd1, 32'hC);
        rd_lit("zero_step_clr", 6'd1, 32'h4);

        // long step aborted by HALT after 10 enabled cycles
        wr(6'd0, 32'h10);
        wr(6'd2, 32'd100);
        wr(6'd0, 32'h4);
        repeat (9) cyc();
        wr(6'd0, 32'h2);
        repeat (3) cyc();
        rd_lit("abort_cycle", 6'd4, 32'd10);
        rd_lit("abort_status", 6'd1, 32'h4);
        rd_lit("stepcnt_rb2", 6'd2, 32'd100);
        rd_lit("bkpt_rb", 6'd3, 32'h101);

        // reset in the middle of a step
        wr(6'd2, 32'd50);
        wr(6'd0, 32'h4);
        repeat (5) cyc();
        rst = 1;
        repeat (2) cyc();
        rst = 0;
        chk("mid_rst_en", 32'(clk_en), 32'd0);
        rd_lit("mid_rst_status", 6'd1, 32'd0);
        rd_lit("mid_rst_cycle", 6'd4, 32'd0);
        rd_lit("mid_rst_stepcnt", 6'd2, 32'd0);
        rd_lit("mid_rst_bkpt", 6'd3, 32'd0);
        rd_lit("mid_rst_snap0", 6'd5, 32'd0);
        rd_lit("mid_rst_snap32", 6'd37, 32'd0);

        // 8-bit instance, running from reset: CYCLE wraps
        rst2 = 0;
        chk("w_en_reset", 32'(clk_en2), 32'd1);
        repeat (255) cyc();
        rd2_lit("wrap_ff", 3'd4, 8'hFF);
        rd2_lit("wrap_00", 3'd4, 8'h00);
        rd2_lit("wrap_01", 3'd4, 8'h01);
        rd2_lit("w_status", 3'd1, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
